// File: rtl/rr_packet_arbiter.sv
// rtl/rr_packet_arbiter.sv - packet-granular round-robin arbiter for val/rdy channels
//
// Shares one val/rdy output channel among p_num_reqs input channels. A winner
// keeps the grant until the beat flagged with in_last has transferred, so
// packets from different requesters never interleave. All data paths are
// combinational: no buffering, at most one beat per cycle.
//
// Optional feature: define RR_PACKET_ARBITER_WATCHDOG_EN to build a 16-bit
// stall counter that sets a sticky err when a locked packet stalls for
// p_timeout consecutive cycles. Undefined: err is tied to 0.
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   in_val/in_rdy    per-requester handshake (in_rdy = grant & out_rdy)
//   in_msg           packed beats, requester i at [i*p_nbits +: p_nbits]
//   in_last          per-requester final-beat flag
//   out_val/out_rdy  shared output handshake
//   out_msg/out_last beat selected by grant
//   grant            one-hot selected requester, zero when none
//   locked           1 while mid-packet
//   err              sticky watchdog error

module rr_packet_arbiter #(
    parameter int p_num_reqs = 4,
    parameter int p_nbits    = 32,
    parameter int p_timeout  = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [p_num_reqs-1:0]         in_val,
    output logic [p_num_reqs-1:0]         in_rdy,
    input  logic [p_num_reqs*p_nbits-1:0] in_msg,
    input  logic [p_num_reqs-1:0]         in_last,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [p_nbits-1:0]            out_msg,
    output logic                          out_last,
    output logic [p_num_reqs-1:0]         grant,
    output logic                          locked,
    output logic                          err
);

    if (p_num_reqs < 2 || p_timeout < 1 || p_timeout > 65535) begin : g_bad_param
        $error("rr_packet_arbiter: illegal parameter value");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [p_num_reqs-1:0]   prio_q, prio_d;
    logic [p_num_reqs-1:0]   owner_q, owner_d;
    logic [p_num_reqs-1:0]   pick;
    logic                    pick_found;
    logic                    xfer;

    // Rotation wraps at bit p_num_reqs-1, so non-power-of-two counts stay legal.
    function automatic logic [p_num_reqs-1:0] rotl1(input logic [p_num_reqs-1:0] v);
        return {v[p_num_reqs-2:0], v[p_num_reqs-1]};
    endfunction

    // Variable-priority pick: offset k from the priority holder is scanned in
    // ascending order, so the first hit is the highest-priority valid requester.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 0; k < p_num_reqs; k++) begin
            for (int j = 0; j < p_num_reqs; j++) begin
                if (!pick_found && prio_q[j] && in_val[(j + k) % p_num_reqs]) begin
                    pick[(j + k) % p_num_reqs] = 1'b1;
                    pick_found                 = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant    = (state_q == ST_LOCK) ? owner_q : pick;
        // In IDLE the pick is non-zero exactly when any in_val is set, so this
        // equals |in_val there and the owner's in_val in LOCK.
        out_val  = |(in_val & grant);
        in_rdy   = grant & {p_num_reqs{out_rdy}};
        out_msg  = '0;
        out_last = 1'b0;
        for (int i = 0; i < p_num_reqs; i++) begin
            if (grant[i]) begin
                out_msg  = out_msg | in_msg[i*p_nbits +: p_nbits];
                out_last = out_last | in_last[i];
            end
        end
        xfer   = out_val & out_rdy;
        locked = (state_q == ST_LOCK);
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (out_last) begin
                        prio_d = rotl1(grant);
                    end else begin
                        state_d = ST_LOCK;
                        owner_d = grant;
                    end
                end
            end
            ST_LOCK: begin
                if (xfer && out_last) begin
                    state_d = ST_IDLE;
                    prio_d  = rotl1(owner_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            prio_q  <= {{(p_num_reqs-1){1'b0}}, 1'b1};
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
        end
    end

`ifdef RR_PACKET_ARBITER_WATCHDOG_EN
    localparam logic [15:0] TIMEOUT = 16'(p_timeout);

    logic [15:0] stall_q, stall_d;
    logic        err_q, err_d;

    // Counter saturates so a very long stall cannot wrap back past TIMEOUT.
    always_comb begin
        stall_d = '0;
        err_d   = err_q;
        if (state_q == ST_LOCK && !xfer) begin
            stall_d = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
        end
        if (stall_d == TIMEOUT) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
- Shares one val/rdy output channel among p_num_reqs val/rdy input channels, arbitrating per packet rather than per beat.
- Arbitration is round-robin. Once a requester wins, it holds the grant until its last beat transfers, so packets from different requesters never interleave.
- Sits in front of shared resources such as a memory port, SPI master or crossbar output, and replaces per-beat round-robin arbitration wherever messages are multi-beat.

Parameters:
- p_num_reqs, 4, number of requesters; must be >= 2.
- p_nbits, 32, message width per beat.
- p_timeout, 255, stall-cycle limit for the optional watchdog; legal range 1..65535.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_val  input  p_num_reqs  per-requester valid.
- in_rdy  output  p_num_reqs  per-requester ready.
- in_msg  input  p_num_reqs*p_nbits  packed messages; requester i occupies bits [i*p_nbits +: p_nbits].
- in_last  input  p_num_reqs  1 = this beat is the final beat of the packet.
- out_val  output  1  shared output valid.
- out_rdy  input  1  shared output ready.
- out_msg  output  p_nbits  selected message.
- out_last  output  1  selected in_last.
- grant  output  p_num_reqs  one-hot selected requester; all zero if none is selected.
- locked  output  1  1 = mid-packet (state LOCK).
- err  output  1  sticky watchdog error.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - State IDLE.
  - Priority register = one-hot bit 0.
  - Owner register = 0.
  - locked = 0, err = 0.
  - grant, out_val and in_rdy follow combinationally from in_val.
- State IDLE:
  - grant = variable-priority pick among in_val. The highest-priority requester is the one-hot priority register; priority then descends cyclically upward in index.
  - grant must not depend on out_rdy.
  - out_val = |in_val.
  - out_msg / out_last are muxed by grant.
  - in_rdy = grant & {p_num_reqs{out_rdy}}.
- Transfer: a transfer occurs when out_val && out_rdy.
- IDLE, transfer with out_last = 1: single-beat packet.
  - Stay in IDLE.
  - Priority <= grant rotated left by 1, so bit p_num_reqs-1 wraps to bit 0.
- IDLE, transfer with out_last = 0:
  - Go to LOCK.
  - Owner <= grant.
  - Priority is unchanged.
- IDLE, no transfer: no state change. The grant may move to a different requester the next cycle if in_val changes. Inputs must hold val until rdy.
- State LOCK:
  - grant = owner; out_val = in_val & owner, reduced (OR).
  - out_msg / out_last come from the owner.
  - in_rdy = owner & out_rdy.
  - All non-owners see in_rdy = 0 regardless of their in_val.
- LOCK, transfer with out_last = 1:
  - Go to IDLE.
  - Priority <= owner rotated left by 1.
- LOCK, owner in_val = 0 (bubble mid-packet): stay in LOCK and keep ownership. out_val = 0.
- Latency: zero-cycle combinational path from input to output. No buffering, and at most one beat per cycle.
- Equivalent combinational paths:
  - in_val → out_val.
  - out_rdy → in_rdy.
  - in_msg → out_msg.
- Reset asserted mid-packet: immediately return to IDLE with priority = bit 0. The partial packet is abandoned, and upstream is responsible for it.
- p_num_reqs not a power of two: rotation still wraps at bit p_num_reqs-1. No illegal grant indices are possible.

Optional Feature:
- Macro: RR_PACKET_ARBITER_WATCHDOG_EN.
- Defined:
  - A 16-bit stall counter increments every cycle in LOCK that has no transfer.
  - It clears on any transfer and on entry to IDLE.
  - When the counter reaches p_timeout, err is set to 1. err stays sticky until reset.
  - err does not alter arbitration.
- Undefined: no counter is built and err is tied to 0.

Test Plan:
- Single-beat round-robin: after reset, in_val = 4'b1111, in_last = 4'b1111, out_rdy = 1 for 4 cycles → grant sequence 0001, 0010, 0100, 1000; then wraps to 0001.
- Packet lock: req1 sends a 3-beat packet (last on beat 3) while req0 and req2 hold in_val = 1 → grant = 0010 for all 3 transfers, with locked = 1 after beat 1. Next grant is 0100, not 0001.
- Backpressure: in LOCK with out_rdy = 0 for 5 cycles → no beat lost, out_msg stable, in_rdy = 0 for all requesters. With out_rdy = 1 the beat then transfers exactly once.
- Owner bubble: the owner drops in_val for 2 cycles mid-packet while req3 is valid → out_val = 0, grant stays on the owner and in_rdy[3] = 0. The packet then completes and req3 wins next.
- Reset mid-packet: assert reset while locked, asynchronously between clock edges → locked = 0 immediately, priority = 0001. With in_val = 1111 the next grant is 0001.
- Watchdog (macro defined, p_timeout = 4): lock, then hold the owner's in_val = 0 → err = 1 after the 4th stall cycle and stays 1 through later transfers until reset. With the macro undefined, err = 0 throughout.
